div_controller: RTL

- Control-path FSM of the unsigned fixed-point divider.
- Sits on the consumer side of the 14-step iteration counter (counter14): drives its cnt_en/sclr, consumes its co.
- Sequences the datapath operations: load, divide-by-zero check, 14 shift/subtract iterations, result.
- Exposes a start/busy/valid handshake to the divider top level.

---
 rtl/div_pkg.sv | 16 +
 rtl/div_controller_if.sv | 37 +++
 rtl/div_controller.sv | 106 ++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the unsigned fixed-point divider.
// Imported by the controller, counter14 and the datapath.
package div_pkg;

  localparam int DIV_ITER = 14;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    ITER  = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_e;

endpackage

// File: rtl/div_controller_if.sv
// Control bundle between the divider controller, datapath and counter14.
// master: divider top side; slave: the controller.
interface div_controller_if;

  logic start;
  logic dz;
  logic lt;
  logic co;
  logic busy;
  logic valid;
  logic dvz_err;
  logic ld_a;
  logic ld_b;
  logic clr_r;
  logic sh_en;
  logic sub_en;
  logic q_bit;
  logic cnt_en;
  logic cnt_sclr;

  modport master (
    output start, dz, lt, co,
    input  busy, valid, dvz_err,
    input  ld_a, ld_b, clr_r,
    input  sh_en, sub_en, q_bit,
    input  cnt_en, cnt_sclr
  );

  modport slave (
    input  start, dz, lt, co,
    output busy, valid, dvz_err,
    output ld_a, ld_b, clr_r,
    output sh_en, sub_en, q_bit,
    output cnt_en, cnt_sclr
  );

endinterface

// File: rtl/div_controller.sv
// Control-path FSM of the unsigned divider: load, zero check,
// shift/subtract iterations paced by counter14, then result.
module div_controller
  import div_pkg::*;
#(
  parameter bit HOLD_VALID = 1'b1,
  parameter int ITER_COUNT = DIV_ITER
) (
  input  logic             clk,
  input  logic             rst,
  div_controller_if.slave  bus
);

  localparam logic [4:0] LP_LAST = 5'(ITER_COUNT - 1);

  state_e r_state;
  state_e w_next;

  logic w_busy;
  logic w_valid;
  logic w_dvz;
  logic w_load;
  logic w_iter;
  logic w_take;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_busy  = 1'b0;
    w_valid = 1'b0;
    w_dvz   = 1'b0;
    w_load  = 1'b0;
    w_iter  = 1'b0;
    w_take  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.start) w_next = LOAD;
      end
      LOAD: begin
        w_busy = 1'b1;
        w_load = 1'b1;
        w_next = CHECK;
      end
      CHECK: begin
        w_busy = 1'b1;
        w_next = bus.dz ? ERR : ITER;
      end
      ITER: begin
        w_busy = 1'b1;
        w_iter = 1'b1;
        w_take = ~bus.lt;
        if (bus.co) w_next = DONE;
      end
      DONE, ERR: begin
        w_valid = 1'b1;
        w_dvz   = (r_state == ERR);
        // a start seen while the result is shown begins the next job
        if (bus.start)       w_next = LOAD;
        else if (!HOLD_VALID) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign bus.busy     = w_busy;
  assign bus.valid    = w_valid;
  assign bus.dvz_err  = w_dvz;
  assign bus.ld_a     = w_load;
  assign bus.ld_b     = w_load;
  assign bus.clr_r    = w_load;
  assign bus.cnt_sclr = w_load;
  assign bus.sh_en    = w_iter;
  assign bus.cnt_en   = w_iter;
  assign bus.sub_en   = w_take;
  assign bus.q_bit    = w_take;

  // run length of the current ITER stay, checked against ITER_COUNT
  logic [4:0] r_iter_len;

  always_ff @(posedge clk) begin
    if (rst)                  r_iter_len <= '0;
    else if (r_state == ITER) r_iter_len <= r_iter_len + 5'd1;
    else                      r_iter_len <= '0;
  end

  a_no_sh_ld: assert property (
    @(posedge clk) disable iff (rst)
    !(bus.sh_en && bus.ld_a));

  a_no_clr_en: assert property (
    @(posedge clk) disable iff (rst)
    !(bus.cnt_sclr && bus.cnt_en));

  a_iter_max: assert property (
    @(posedge clk) disable iff (rst)
    (r_state == ITER) |-> (r_iter_len <= LP_LAST));

  a_iter_exact: assert property (
    @(posedge clk) disable iff (rst)
    (r_state == ITER && bus.co) |-> (r_iter_len == LP_LAST));

endmodule
